// File: rtl/mem_port_arbiter.sv
// Sequencing controller in front of a single-port word BRAM: arbitrates fetch and
// data requesters, turns partial-word stores into read-modify-write, drives active-low strobes.
module mem_port_arbiter #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = WORDS + 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_ready_o,
    output logic                    if_rsp_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_ready_o,
    output logic                    d_rsp_o,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic                    busy_o,
    output logic [WORDS-1:0]        mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    output logic                    mem_rd_o,
    output logic                    mem_wr_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [WORDS-1:0]        addr_r;
    logic                    port_d_r;
    logic                    we_r;
    logic [BE_WIDTH-1:0]     be_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    wr_en_r;
    logic                    last_d_r;
    logic [DATA_WIDTH-1:0]   mem_data_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic                    if_rsp_r;
    logic                    d_rsp_r;
    logic                    grant_if_s;
    logic                    grant_d_s;
    logic                    unused_s;

    // Lane-wise merge: enabled lanes from the new word, the rest from the old word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int n = 0; n < BE_WIDTH; n++) begin
            res[8*n +: 8] = be[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
        end
        return res;
    endfunction

    assign unused_s = ^{if_addr_i[1:0], d_addr_i[1:0]};

    // Round-robin grant, only offered in IDLE and never while reset is held.
    always_comb begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if (reset_i || (state_r != IDLE)) begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end else if (d_req_i && (!if_req_i || !last_d_r)) begin
            grant_d_s = 1'b1;
        end else if (if_req_i) begin
            grant_if_s = 1'b1;
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
    end

    // Next-state decode: partial stores take the read leg first.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_if_s) begin
                    state_nxt_s = RD;
                end else if (grant_d_s) begin
                    if (!d_we_i) begin
                        state_nxt_s = RD;
                    end else if ((d_be_i == {BE_WIDTH{1'b1}}) || (d_be_i == {BE_WIDTH{1'b0}})) begin
                        state_nxt_s = WR;
                    end else begin
                        state_nxt_s = RD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD: begin
                if (port_d_r && we_r) begin
                    state_nxt_s = WR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, latched request fields, write data and response pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            addr_r     <= {WORDS{1'b0}};
            port_d_r   <= 1'b0;
            we_r       <= 1'b0;
            be_r       <= {BE_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wr_en_r    <= 1'b0;
            last_d_r   <= 1'b0;
            mem_data_r <= {DATA_WIDTH{1'b0}};
            rsp_data_r <= {DATA_WIDTH{1'b0}};
            if_rsp_r   <= 1'b0;
            d_rsp_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            if_rsp_r <= 1'b0;
            d_rsp_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_if_s || grant_d_s) begin
                        last_d_r <= grant_d_s;
                        port_d_r <= grant_d_s;
                        addr_r   <= grant_d_s ? d_addr_i[ADDR_WIDTH-1:2] : if_addr_i[ADDR_WIDTH-1:2];
                        we_r     <= grant_d_s && d_we_i;
                        be_r     <= d_be_i;
                        wdata_r  <= d_wdata_i;
                        // An all-zero mask still walks through WR, but without a strobe.
                        wr_en_r  <= grant_d_s && d_we_i && (d_be_i != {BE_WIDTH{1'b0}});
                        if (grant_d_s && d_we_i) begin
                            mem_data_r <= d_wdata_i;
                        end
                    end
                end
                RD: begin
                    if (port_d_r && we_r) begin
                        mem_data_r <= merge_lanes(mem_data_i, wdata_r, be_r);
                    end else begin
                        rsp_data_r <= mem_data_i;
                        if_rsp_r   <= !port_d_r;
                        d_rsp_r    <= port_d_r;
                    end
                end
                WR:      d_rsp_r <= 1'b1;
                default: d_rsp_r <= 1'b0;
            endcase
        end
    end

    assign if_ready_o = grant_if_s;
    assign d_ready_o  = grant_d_s;
    assign if_rsp_o   = if_rsp_r;
    assign d_rsp_o    = d_rsp_r;
    assign rsp_data_o = rsp_data_r;
    assign busy_o     = (state_r != IDLE);
    assign mem_addr_o = addr_r;
    assign mem_data_o = mem_data_r;
    assign mem_rd_o   = (state_r != RD);
    assign mem_wr_o   = !((state_r == WR) && wr_en_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a negedge-sampling BRAM
// model and a word-array reference of memory contents and response timing.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [11:0] if_addr_i;
    logic        if_ready_o;
    logic        if_rsp_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [11:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_ready_o;
    logic        d_rsp_o;
    logic [31:0] rsp_data_o;
    logic        busy_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_rd_o;
    logic        mem_wr_o;

    logic [31:0] mem [0:1023];
    logic [31:0] shadow [0:1023];
    int          errors = 0;
    int          checks = 0;
    int          wr_count = 0;

    mem_port_arbiter dut (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_rsp_o(if_rsp_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_ready_o(d_ready_o), .d_rsp_o(d_rsp_o),
        .rsp_data_o(rsp_data_o), .busy_o(busy_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o)
    );

    always #5 clk = ~clk;

    // BRAM model: strobes and address sampled on the falling edge.
    always @(negedge clk) begin
        checks++;
        assert (!(!mem_rd_o && !mem_wr_o)) else begin
            errors++;
            $error("FAIL strobe_overlap: observed rd=%b wr=%b expected not both low", mem_rd_o, mem_wr_o);
        end
        if (!mem_wr_o) begin
            mem[mem_addr_o] = mem_data_o;
            wr_count++;
        end
        if (!mem_rd_o) mem_data_i = mem[mem_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int n = 0; n < 4; n++) if (be[n]) r[8*n +: 8] = new_w[8*n +: 8];
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, 32'(mem_rd_o), 32'd1);
        check({tag, "_wr"}, 32'(mem_wr_o), 32'd1);
        check({tag, "_rsp"}, 32'({if_rsp_o, d_rsp_o}), 32'd0);
        check({tag, "_ready"}, 32'({if_ready_o, d_ready_o}), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_rdata"}, rsp_data_o, 32'd0);
        check({tag, "_maddr"}, 32'(mem_addr_o), 32'd0);
        check({tag, "_mdata"}, mem_data_o, 32'd0);
    endtask

    // One transaction from a single requester; called at posedge+1 with the DUT idle.
    task automatic transact(input bit is_d, input bit we, input logic [3:0] be,
                            input logic [11:0] addr, input logic [31:0] wd);
        logic [9:0]  widx;
        logic [31:0] old_w;
        bit          rd_path, full, rmw;
        int          n;
        widx    = addr[11:2];
        old_w   = shadow[widx];
        rd_path = !is_d || !we;
        full    = is_d && we && (be == 4'hF);
        rmw     = is_d && we && (be != 4'h0) && (be != 4'hF);
        if (is_d) begin
            d_req_i = 1'b1; d_we_i = we; d_be_i = be; d_addr_i = addr; d_wdata_i = wd;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        #1;
        n = 0;
        while (!(is_d ? d_ready_o : if_ready_o) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready", 32'(is_d ? d_ready_o : if_ready_o), 32'd1);
        @(posedge clk); #1;
        d_req_i = 1'b0; if_req_i = 1'b0;
        check("t0_addr", 32'(mem_addr_o), 32'(widx));
        check("t0_busy", 32'(busy_o), 32'd1);
        check("t0_rd", 32'(mem_rd_o), 32'(!(rd_path || rmw)));
        check("t0_wr", 32'(mem_wr_o), 32'(!full));
        check("t0_no_rsp", 32'({if_rsp_o, d_rsp_o}), 32'd0);
        if (full) check("t0_wdata", mem_data_o, wd);
        @(posedge clk); #1;
        if (rmw) begin
            check("rmw_wr", 32'(mem_wr_o), 32'd0);
            check("rmw_rd", 32'(mem_rd_o), 32'd1);
            check("rmw_data", mem_data_o, merge(old_w, wd, be));
            check("rmw_no_rsp", 32'(d_rsp_o), 32'd0);
            @(posedge clk); #1;
        end
        check("d_rsp", 32'(d_rsp_o), 32'(is_d));
        check("if_rsp", 32'(if_rsp_o), 32'(!is_d));
        check("rsp_busy", 32'(busy_o), 32'd0);
        if (rd_path) check("rsp_data", rsp_data_o, old_w);
        if (is_d && we) shadow[widx] = merge(old_w, wd, be);
    endtask

    initial begin
        bit          exp_last_d;
        bit          exp_grant_d;
        int          rsp_port;
        int          wc;
        logic [31:0] word_before;
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        mem[10] = 32'h55AA3312;
        shadow[10] = 32'h55AA3312;
        reset_i = 1'b1; if_req_i = 1'b0; if_addr_i = 12'h000; d_req_i = 1'b0;
        d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 12'h000; d_wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_i = 1'b0;

        transact(1'b0, 1'b0, 4'h0, 12'h028, 32'h0);
        check("plan_fetch", rsp_data_o, 32'h55AA3312);
        transact(1'b1, 1'b1, 4'hF, 12'h040, 32'hDEADBEEF);
        transact(1'b1, 1'b0, 4'h0, 12'h040, 32'h0);
        check("plan_full_load", rsp_data_o, 32'hDEADBEEF);
        transact(1'b1, 1'b1, 4'b0010, 12'h029, 32'h00007700);
        transact(1'b1, 1'b0, 4'h0, 12'h028, 32'h0);
        check("plan_rmw_load", rsp_data_o, 32'h55AA7712);
        wc = wr_count;
        word_before = mem[12'h030 >> 2];
        transact(1'b1, 1'b1, 4'h0, 12'h030, 32'hFFFFFFFF);
        check("empty_no_write", 32'(wr_count), 32'(wc));
        check("empty_mem", mem[12'h030 >> 2], word_before);

        // Reset during the read leg of a partial store.
        wc = wr_count;
        word_before = mem[10];
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0100; d_addr_i = 12'h028; d_wdata_i = 32'h00990000;
        #1;
        check("abort_ready", 32'(d_ready_o), 32'd1);
        @(posedge clk); #1;
        check("abort_in_rd", 32'(mem_rd_o), 32'd0);
        reset_i = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        check("abort_no_write", 32'(wr_count), 32'(wc));
        check("abort_mem", mem[10], word_before);
        d_req_i = 1'b0;
        reset_i = 1'b0;
        transact(1'b1, 1'b0, 4'h0, 12'h028, 32'h0);

        // Both ports requesting loads straight out of reset.
        reset_i = 1'b1;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 12'h040;
        if_req_i = 1'b1; if_addr_i = 12'h028;
        @(posedge clk); #1;
        check("arb_reset_ready", 32'({if_ready_o, d_ready_o}), 32'd0);
        reset_i = 1'b0;
        #1;
        exp_last_d = 1'b0;
        rsp_port = -1;
        for (int k = 0; k < 4; k++) begin
            exp_grant_d = !exp_last_d;
            check("arb_d_ready", 32'(d_ready_o), 32'(exp_grant_d));
            check("arb_if_ready", 32'(if_ready_o), 32'(!exp_grant_d));
            if (rsp_port >= 0) begin
                check("arb_d_rsp", 32'(d_rsp_o), 32'(rsp_port == 1));
                check("arb_if_rsp", 32'(if_rsp_o), 32'(rsp_port == 0));
                check("arb_rsp_data", rsp_data_o, (rsp_port == 1) ? shadow[16] : shadow[10]);
            end
            exp_last_d = exp_grant_d;
            rsp_port = exp_grant_d ? 1 : 0;
            @(posedge clk); #1;
            check("arb_rd_ready", 32'({if_ready_o, d_ready_o}), 32'd0);
            check("arb_rd_strobe", 32'(mem_rd_o), 32'd0);
            @(posedge clk); #1;
        end
        d_req_i = 1'b0; if_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int t = 0; t < 40; t++) begin
            bit          rd_d, rd_we;
            logic [3:0]  rbe;
            logic [11:0] raddr;
            int          sel;
            rd_d  = 1'($urandom_range(0, 1));
            rd_we = rd_d && 1'($urandom_range(0, 1));
            sel   = int'($urandom_range(0, 3));
            rbe   = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom);
            raddr = 12'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
            transact(rd_d, rd_we, rbe, raddr, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
